// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the SWT16 data-memory load/store unit.
package dmem_lsu_pkg;

  // The datapath is built around two byte lanes, so the word width is fixed.
  localparam int LSU_WORD_WIDTH = 16;
  localparam int LSU_ADDR_WIDTH = 12;

  // Cycles from the accept cycle to the response pulse, per request kind.
  localparam int LAT_WORD_STORE = 2;
  localparam int LAT_ERROR      = 2;
  localparam int LAT_LOAD       = 3;
  localparam int LAT_BYTE_STORE = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_RMW_WR  = 3'd3,
    ST_ERR     = 3'd4
  } lsu_state_e;

  // A word access to an odd byte address cannot be served by the word-wide dmem.
  function automatic logic is_misaligned(input logic is_byte, input logic addr_lsb);
    return !is_byte && addr_lsb;
  endfunction

endpackage

// File: rtl/dmem_lsu_byte_lane.sv
// Byte-lane helper: extracts a byte for loads and merges a byte for stores.
// Lanes are little-endian: lane 0 is bits [7:0], lane 1 is bits [15:8].
module dmem_byte_lane
  import dmem_lsu_pkg::*;
(
  input  logic [LSU_WORD_WIDTH-1:0] load_word,
  input  logic                      lane,
  input  logic                      is_signed,
  input  logic [7:0]                store_byte,
  output logic [LSU_WORD_WIDTH-1:0] load_result,
  output logic [LSU_WORD_WIDTH-1:0] store_merged
);

  logic [7:0] lane_byte;

  // Select the addressed lane, extend it, and build the read-modify-write word.
  always_comb begin
    lane_byte    = lane ? load_word[15:8] : load_word[7:0];
    load_result  = {{8{is_signed & lane_byte[7]}}, lane_byte};
    store_merged = lane ? {store_byte, load_word[7:0]} : {load_word[15:8], store_byte};
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for the SWT16 data memory: one request per handshake,
// byte loads by lane extract, byte stores by read-modify-write.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int WORD_WIDTH = LSU_WORD_WIDTH,
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_req_valid,
  output logic                  out_req_ready,
  input  logic                  in_req_we,
  input  logic                  in_req_byte,
  input  logic                  in_req_signed,
  input  logic [ADDR_WIDTH-1:0] in_req_addr,
  input  logic [WORD_WIDTH-1:0] in_req_wdata,
  output logic                  out_rsp_valid,
  output logic                  out_rsp_err,
  output logic [WORD_WIDTH-1:0] out_rsp_rdata,
  output logic [ADDR_WIDTH-1:0] out_mem_addr_rd,
  output logic [ADDR_WIDTH-1:0] out_mem_addr_wr,
  output logic [WORD_WIDTH-1:0] out_mem_word,
  output logic                  out_mem_write_en,
  input  logic [WORD_WIDTH-1:0] in_mem_word
);

  lsu_state_e state_q, state_d;

  logic                  req_we_q, req_we_d;
  logic                  req_byte_q, req_byte_d;
  logic                  req_signed_q, req_signed_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [WORD_WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic [WORD_WIDTH-1:0] merge_q, merge_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [WORD_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  accept;
  logic                  word_store_issue;
  logic [WORD_WIDTH-1:0] lane_load;
  logic [WORD_WIDTH-1:0] lane_merged;

  dmem_byte_lane u_byte_lane (
    .load_word    (in_mem_word),
    .lane         (req_addr_q[0]),
    .is_signed    (req_signed_q),
    .store_byte   (req_wdata_q[7:0]),
    .load_result  (lane_load),
    .store_merged (lane_merged)
  );

  // Handshake and dmem port drive; everything is forced quiet while reset is high.
  always_comb begin
    out_req_ready    = (state_q == ST_IDLE) && !reset;
    accept           = in_req_valid && out_req_ready;
    word_store_issue = (state_q == ST_ISSUE) && req_we_q && !req_byte_q;
    out_mem_write_en = !reset && (word_store_issue || (state_q == ST_RMW_WR));
    out_mem_addr_rd  = (!reset && (state_q == ST_ISSUE)) ? req_addr_q : '0;
    out_mem_addr_wr  = out_mem_write_en ? req_addr_q : '0;
    out_mem_word     = '0;
    if (out_mem_write_en) begin
      out_mem_word = word_store_issue ? req_wdata_q : merge_q;
    end
    out_rsp_valid    = rsp_valid_q && !reset;
    out_rsp_err      = rsp_err_q && !reset;
    out_rsp_rdata    = reset ? '0 : rsp_rdata_q;
  end

  // Next-state, request latch and response computation for the access sequence.
  always_comb begin
    state_d      = state_q;
    req_we_d     = req_we_q;
    req_byte_d   = req_byte_q;
    req_signed_d = req_signed_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    merge_d      = merge_q;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_rdata_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_we_d     = in_req_we;
          req_byte_d   = in_req_byte;
          req_signed_d = in_req_signed;
          req_addr_d   = in_req_addr;
          req_wdata_d  = in_req_wdata;
          state_d      = is_misaligned(in_req_byte, in_req_addr[0]) ? ST_ERR : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (req_we_q && !req_byte_q) begin
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (req_we_q) begin
          merge_d = lane_merged;
          state_d = ST_RMW_WR;
        end else begin
          rsp_rdata_d = req_byte_q ? lane_load : in_mem_word;
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_RMW_WR: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request and response registers; reset aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_we_q     <= 1'b0;
      req_byte_q   <= 1'b0;
      req_signed_q <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      merge_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_we_q     <= req_we_d;
      req_byte_q   <= req_byte_d;
      req_signed_q <= req_signed_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      merge_q      <= merge_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu with a behavioural 1-cycle-read data memory.
module tb_dmem_lsu;

  typedef struct {
    int          cyc;
    logic        err;
    logic [15:0] rdata;
    string       name;
  } rsp_exp_t;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [15:0] data;
    string       name;
  } wr_exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_req_valid = 1'b0;
  logic        out_req_ready;
  logic        in_req_we = 1'b0;
  logic        in_req_byte = 1'b0;
  logic        in_req_signed = 1'b0;
  logic [11:0] in_req_addr = '0;
  logic [15:0] in_req_wdata = '0;
  logic        out_rsp_valid;
  logic        out_rsp_err;
  logic [15:0] out_rsp_rdata;
  logic [11:0] out_mem_addr_rd;
  logic [11:0] out_mem_addr_wr;
  logic [15:0] out_mem_word;
  logic        out_mem_write_en;
  logic [15:0] in_mem_word;

  logic [15:0] mem [0:2047];
  logic [11:0] rd_addr_q = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rsp_exp_t rsp_q[$];
  wr_exp_t  wr_q[$];

  dmem_lsu dut (
    .clock            (clock),
    .reset            (reset),
    .in_req_valid     (in_req_valid),
    .out_req_ready    (out_req_ready),
    .in_req_we        (in_req_we),
    .in_req_byte      (in_req_byte),
    .in_req_signed    (in_req_signed),
    .in_req_addr      (in_req_addr),
    .in_req_wdata     (in_req_wdata),
    .out_rsp_valid    (out_rsp_valid),
    .out_rsp_err      (out_rsp_err),
    .out_rsp_rdata    (out_rsp_rdata),
    .out_mem_addr_rd  (out_mem_addr_rd),
    .out_mem_addr_wr  (out_mem_addr_wr),
    .out_mem_word     (out_mem_word),
    .out_mem_write_en (out_mem_write_en),
    .in_mem_word      (in_mem_word)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Word-granular synchronous-write memory with a registered read address.
  always @(posedge clock) begin
    if (out_mem_write_en) mem[out_mem_addr_wr[11:1]] <= out_mem_word;
    rd_addr_q <= out_mem_addr_rd;
  end
  assign in_mem_word = mem[rd_addr_q[11:1]];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: pops expected responses and writes whenever the DUT presents them.
  always @(negedge clock) begin
    rsp_exp_t r;
    wr_exp_t  w;
    if (out_rsp_valid) begin
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got rsp_valid at cycle %0d, expected none", cyc);
      end else begin
        r = rsp_q.pop_front();
        check({r.name, "_rsp_cycle"}, cyc, r.cyc);
        check({r.name, "_rsp_err"}, {31'd0, out_rsp_err}, {31'd0, r.err});
        check({r.name, "_rsp_rdata"}, {16'd0, out_rsp_rdata}, {16'd0, r.rdata});
      end
    end
    if (out_mem_write_en) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got write_en at cycle %0d addr 0x%0h, expected none",
                 cyc, out_mem_addr_wr);
      end else begin
        w = wr_q.pop_front();
        check({w.name, "_wr_cycle"}, cyc, w.cyc);
        check({w.name, "_wr_addr"}, {21'd0, out_mem_addr_wr[11:1]}, {21'd0, w.addr[11:1]});
        check({w.name, "_wr_data"}, {16'd0, out_mem_word}, {16'd0, w.data});
      end
    end
  end

  // Drives one request at a falling edge, waits for ready, and records expectations.
  task automatic applyStimulus(input logic we, input logic byt, input logic sgn,
                               input logic [11:0] addr, input logic [15:0] wdata,
                               input int rsp_lat, input logic exp_err, input logic [15:0] exp_rdata,
                               input int wr_lat, input logic [15:0] wr_data,
                               input string name, output int acc_cyc);
    bit ok;
    rsp_exp_t r;
    wr_exp_t  w;
    ok = 1'b0;
    in_req_we     = we;
    in_req_byte   = byt;
    in_req_signed = sgn;
    in_req_addr   = addr;
    in_req_wdata  = wdata;
    in_req_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    acc_cyc = -1;
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_accept: got ready=0 for 20 cycles, expected ready=1", name);
      in_req_valid = 1'b0;
    end else begin
      acc_cyc = cyc;
      if (rsp_lat > 0) begin
        r.cyc = acc_cyc + rsp_lat; r.err = exp_err; r.rdata = exp_rdata; r.name = name;
        rsp_q.push_back(r);
      end
      if (wr_lat > 0) begin
        w.cyc = acc_cyc + wr_lat; w.addr = addr; w.data = wr_data; w.name = name;
        wr_q.push_back(w);
      end
      @(posedge clock);
      @(negedge clock);
      in_req_valid = 1'b0;
    end
  endtask

  // Reset-state checks sampled mid-cycle.
  task automatic checkOutput(input string name, input logic exp_ready);
    check({name, "_ready"}, {31'd0, out_req_ready}, {31'd0, exp_ready});
    check({name, "_rsp_valid"}, {31'd0, out_rsp_valid}, 32'd0);
    check({name, "_write_en"}, {31'd0, out_mem_write_en}, 32'd0);
    check({name, "_rdata"}, {16'd0, out_rsp_rdata}, 32'd0);
    check({name, "_addr_rd"}, {20'd0, out_mem_addr_rd}, 32'd0);
    check({name, "_addr_wr"}, {20'd0, out_mem_addr_wr}, 32'd0);
    check({name, "_mem_word"}, {16'd0, out_mem_word}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion by time limit, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ac;
    // Reset held for three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("in_reset", 1'b0);
    end
    reset = 1'b0;
    #1;
    checkOutput("post_reset", 1'b1);
    @(negedge clock);
    checkOutput("post_reset2", 1'b1);

    // Word store then word load of the same address in the store's response cycle.
    applyStimulus(1, 0, 0, 12'h010, 16'hBEEF, 2, 0, 16'h0000, 1, 16'hBEEF, "st_w_010", ac);
    applyStimulus(0, 0, 0, 12'h010, 16'h0000, 3, 0, 16'hBEEF, 0, 16'h0, "ld_w_010", ac);

    // Byte loads with sign and zero extension over 0x80F1.
    applyStimulus(1, 0, 0, 12'h020, 16'h80F1, 2, 0, 16'h0000, 1, 16'h80F1, "st_w_020", ac);
    applyStimulus(0, 1, 1, 12'h021, 16'h0000, 3, 0, 16'hFF80, 0, 16'h0, "ld_bs_021", ac);
    applyStimulus(0, 1, 0, 12'h021, 16'h0000, 3, 0, 16'h0080, 0, 16'h0, "ld_bu_021", ac);
    applyStimulus(0, 1, 1, 12'h020, 16'h0000, 3, 0, 16'hFFF1, 0, 16'h0, "ld_bs_020", ac);
    applyStimulus(0, 1, 0, 12'h020, 16'h0000, 3, 0, 16'h00F1, 0, 16'h0, "ld_bu_020", ac);

    // Byte stores into each lane by read-modify-write.
    applyStimulus(1, 0, 0, 12'h040, 16'h1234, 2, 0, 16'h0000, 1, 16'h1234, "st_w_040", ac);
    applyStimulus(1, 1, 0, 12'h041, 16'h005A, 4, 0, 16'h0000, 3, 16'h5A34, "st_b_041", ac);
    applyStimulus(0, 0, 0, 12'h040, 16'h0000, 3, 0, 16'h5A34, 0, 16'h0, "ld_w_040a", ac);
    applyStimulus(0, 1, 0, 12'h040, 16'h0000, 3, 0, 16'h0034, 0, 16'h0, "ld_bu_040", ac);
    applyStimulus(1, 1, 0, 12'h040, 16'hFFC3, 4, 0, 16'h0000, 3, 16'h5AC3, "st_b_040", ac);
    applyStimulus(0, 0, 0, 12'h040, 16'h0000, 3, 0, 16'h5AC3, 0, 16'h0, "ld_w_040b", ac);

    // Misaligned word accesses: error response, never a write.
    applyStimulus(0, 0, 0, 12'h031, 16'h0000, 2, 1, 16'h0000, 0, 16'h0, "ld_mis_031", ac);
    applyStimulus(1, 0, 0, 12'h033, 16'h7777, 2, 1, 16'h0000, 0, 16'h0, "st_mis_033", ac);

    // Reset during the write cycle of a byte store aborts it entirely.
    applyStimulus(1, 0, 0, 12'h050, 16'h1111, 2, 0, 16'h0000, 1, 16'h1111, "st_w_050", ac);
    applyStimulus(1, 1, 0, 12'h051, 16'h00EE, 0, 0, 16'h0000, 0, 16'h0, "st_b_051", ac);
    if (ac >= 0) begin
      while (cyc < ac + 3) begin
        @(posedge clock);
        #1;
      end
      #1;
      reset = 1'b1;
      @(negedge clock);
      check("rmw_reset_write_en", {31'd0, out_mem_write_en}, 32'd0);
      check("rmw_reset_ready", {31'd0, out_req_ready}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("rmw_release_ready", {31'd0, out_req_ready}, 32'd1);
      @(negedge clock);
      check("rmw_release_rsp_valid", {31'd0, out_rsp_valid}, 32'd0);
    end
    applyStimulus(0, 0, 0, 12'h050, 16'h0000, 3, 0, 16'h1111, 0, 16'h0, "ld_w_050", ac);

    // Drain the scoreboard.
    for (int i = 0; i < 20; i++) begin
      if (rsp_q.size() == 0 && wr_q.size() == 0) break;
      @(negedge clock);
    end
    repeat (3) @(negedge clock);
    check("rsp_queue_empty", rsp_q.size(), 32'd0);
    check("wr_queue_empty", wr_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
